// File: rtl/y86_pkg.sv
// rtl/y86_pkg.sv - shared Y86 constants: icodes, status codes, sequencer states, CC bit indices
package y86_pkg;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [1:0] STAT_AOK = 2'd0;
  localparam logic [1:0] STAT_HLT = 2'd1;
  localparam logic [1:0] STAT_ADR = 2'd2;
  localparam logic [1:0] STAT_INS = 2'd3;

  localparam int CC_ZF = 0;
  localparam int CC_SF = 1;
  localparam int CC_OF = 2;

  // zf=1 out of reset so a bare "je" before any OPq is taken
  localparam logic [2:0] CC_RESET = 3'b001;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXECUTE,
    S_MEMORY,
    S_WRITEBACK,
    S_PCUPD,
    S_HALT
  } state_t;

  // Instructions that touch data memory and therefore pass through MEMORY
  function automatic logic uses_mem(input logic [3:0] code);
    return (code == I_RMMOVQ) || (code == I_MRMOVQ) || (code == I_CALL) ||
           (code == I_RET)    || (code == I_PUSHQ)  || (code == I_POPQ);
  endfunction

endpackage

// File: rtl/y86_cond_eval.sv
// rtl/y86_cond_eval.sv - combinational jXX/cmovXX condition from ifun and condition codes
module y86_cond_eval
  import y86_pkg::*;
(
  input  logic [3:0] ifun,
  input  logic [2:0] cc,
  output logic       cnd
);

  logic zf, sf, of_, lt;

  assign zf  = cc[CC_ZF];
  assign sf  = cc[CC_SF];
  assign of_ = cc[CC_OF];
  assign lt  = sf ^ of_;

  // Decode the condition field; unknown function codes are never taken
  always_comb begin
    cnd = 1'b0;
    case (ifun)
      4'd0:    cnd = 1'b1;
      4'd1:    cnd = lt | zf;
      4'd2:    cnd = lt;
      4'd3:    cnd = zf;
      4'd4:    cnd = ~zf;
      4'd5:    cnd = ~lt;
      4'd6:    cnd = ~lt & ~zf;
      default: cnd = 1'b0;
    endcase
  end

endmodule

// File: rtl/y86_seq_controller.sv
// rtl/y86_seq_controller.sv - sequential Y86 stage sequencer, CC/cnd owner, status; PERF_CNT_EN enables counters
module y86_seq_controller
  import y86_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       icode,
  input  logic [3:0]       ifun,
  input  logic             instr_valid,
  input  logic             imem_error,
  input  logic [2:0]       alu_flags,
  input  logic             dmem_ack,
  input  logic             dmem_error,
  output logic             fetch_en,
  output logic             decode_en,
  output logic             exec_en,
  output logic             mem_en,
  output logic             wb_en,
  output logic             pc_en,
  output logic             dmem_req,
  output logic [2:0]       cc,
  output logic             cnd,
  output logic [1:0]       stat,
  output logic             halted,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instr_cnt
);

  state_t      state;
  logic [31:0] wait_cnt;
  logic        cond_raw;
  logic        wait_expired;
  logic        is_branchy;

  y86_cond_eval u_cond_eval (
    .ifun (ifun),
    .cc   (cc),
    .cnd  (cond_raw)
  );

  // MEM_TIMEOUT of 0 means a memory access may stall indefinitely
  assign wait_expired = (MEM_TIMEOUT != 0) && (wait_cnt == 32'(MEM_TIMEOUT - 1));
  assign is_branchy   = (icode == I_RRMOVQ) || (icode == I_JXX);

  // Stage sequencer; enables are registered alongside the state they belong to
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      fetch_en  <= 1'b0;
      decode_en <= 1'b0;
      exec_en   <= 1'b0;
      mem_en    <= 1'b0;
      wb_en     <= 1'b0;
      pc_en     <= 1'b0;
      dmem_req  <= 1'b0;
      cc        <= CC_RESET;
      cnd       <= 1'b0;
      stat      <= STAT_AOK;
      halted    <= 1'b0;
      wait_cnt  <= '0;
    end else begin
      fetch_en  <= 1'b0;
      decode_en <= 1'b0;
      exec_en   <= 1'b0;
      mem_en    <= 1'b0;
      wb_en     <= 1'b0;
      pc_en     <= 1'b0;
      dmem_req  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state    <= S_FETCH;
            fetch_en <= 1'b1;
          end
        end
        S_FETCH: begin
          state     <= S_DECODE;
          decode_en <= 1'b1;
        end
        S_DECODE: begin
          if (imem_error) begin
            state  <= S_HALT;
            stat   <= STAT_ADR;
            halted <= 1'b1;
          end else if (!instr_valid) begin
            state  <= S_HALT;
            stat   <= STAT_INS;
            halted <= 1'b1;
          end else if (icode == I_HALT) begin
            state  <= S_HALT;
            stat   <= STAT_HLT;
            halted <= 1'b1;
          end else begin
            state   <= S_EXECUTE;
            exec_en <= 1'b1;
          end
        end
        S_EXECUTE: begin
          // cnd is evaluated against the flags from the previous OPq
          cnd <= is_branchy ? cond_raw : 1'b0;
          if (icode == I_OPQ) begin
            cc <= alu_flags;
          end
          if (uses_mem(icode)) begin
            state    <= S_MEMORY;
            mem_en   <= 1'b1;
            dmem_req <= 1'b1;
            wait_cnt <= '0;
          end else begin
            state <= S_WRITEBACK;
            wb_en <= 1'b1;
          end
        end
        S_MEMORY: begin
          // An ack arriving on the timeout cycle is honoured as a normal completion
          if (dmem_ack) begin
            if (dmem_error) begin
              state  <= S_HALT;
              stat   <= STAT_ADR;
              halted <= 1'b1;
            end else begin
              state <= S_WRITEBACK;
              wb_en <= 1'b1;
            end
          end else if (wait_expired) begin
            state  <= S_HALT;
            stat   <= STAT_ADR;
            halted <= 1'b1;
          end else begin
            mem_en   <= 1'b1;
            dmem_req <= 1'b1;
            wait_cnt <= wait_cnt + 32'd1;
          end
        end
        S_WRITEBACK: begin
          state <= S_PCUPD;
          pc_en <= 1'b1;
        end
        S_PCUPD: begin
          state    <= S_FETCH;
          fetch_en <= 1'b1;
        end
        S_HALT: begin
          state <= S_HALT;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

`ifdef PERF_CNT_EN
  // Active-cycle and retired-instruction counters, both free-running with wrap
  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_cnt <= '0;
      instr_cnt <= '0;
    end else begin
      if (state != S_IDLE && state != S_HALT) begin
        cycle_cnt <= cycle_cnt + 1'b1;
      end
      if (state == S_PCUPD) begin
        instr_cnt <= instr_cnt + 1'b1;
      end
    end
  end
`else
  assign cycle_cnt = '0;
  assign instr_cnt = '0;
`endif

endmodule
